// File: rtl/mac_result_tx_serializer.sv
// Captures a MAC result and streams it, optionally behind a header byte, to a
// byte-wide UART transmitter through a start-pulse / tx_busy handshake.
module mac_result_tx_serializer #(
    parameter int          DATA_WIDTH  = 48,
    parameter int          NUM_BYTES   = DATA_WIDTH / 8,
    parameter bit          SEND_HEADER = 1'b1,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_p,
    input  logic                  result_valid,
    input  logic                  tx_busy,
    output logic                  tx_start_transmission,
    output logic [7:0]            tx_data_in,
    output logic                  ready,
    output logic                  frame_done,
    output logic                  overflow,
    output logic                  ack_timeout_err
);

    localparam int TOTAL = NUM_BYTES + (SEND_HEADER ? 1 : 0);
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(TOTAL - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  tx_start_q, tx_start_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  ready_q, ready_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overflow_q, overflow_d;
    logic                  ack_err_q, ack_err_d;
    logic                  is_hdr;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        byte_cnt_d   = byte_cnt_q;
        tmo_d        = tmo_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        ack_err_d    = ack_err_q;
        is_hdr       = SEND_HEADER && (byte_cnt_q == '0);

        // Results arriving mid-frame park in the single pending slot or are lost.
        if (state_q != IDLE && result_valid) begin
            if (!pend_vld_q) begin
                pend_d     = data_p;
                pend_vld_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (pend_vld_q) begin
                    shift_d    = pend_q;
                    byte_cnt_d = '0;
                    state_d    = START;
                    pend_vld_d = result_valid;
                    if (result_valid) pend_d = data_p;
                end else if (result_valid) begin
                    shift_d    = data_p;
                    byte_cnt_d = '0;
                    state_d    = START;
                end
            end
            START: begin
                tx_data_d  = is_hdr ? HEADER_BYTE : shift_q[7:0];
                tx_start_d = 1'b1;
                tmo_d      = '0;
                state_d    = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (tmo_q == TMO_LAST) begin
                    // Give up on the acknowledge and move on as if the byte went out.
                    ack_err_d = 1'b1;
                    state_d   = WAIT_LO;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        if (!is_hdr) shift_d = shift_q >> 8;
                        state_d = START;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE) && !pend_vld_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            byte_cnt_q   <= '0;
            tmo_q        <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            ready_q      <= 1'b1;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            ack_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            byte_cnt_q   <= byte_cnt_d;
            tmo_q        <= tmo_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            ack_err_q    <= ack_err_d;
        end
    end

    assign tx_start_transmission = tx_start_q;
    assign tx_data_in            = tx_data_q;
    assign ready                 = ready_q;
    assign frame_done            = frame_done_q;
    assign overflow              = overflow_q;
    assign ack_timeout_err       = ack_err_q;

endmodule
